ex_stage_mc: RTL
================

Name: ex_stage_mc

Overview:
Parametrised execute stage for the pipelined core.
- Selects operands through two-source forwarding muxes and computes single-cycle ALU ops.
- Adds an iterative multi-cycle multiplier that stalls the front of the pipe while busy.
- Holds the N/Z/V flag register with per-op update rules.
- Sits between ID/EX and EX/MEM. Its registered outputs form the EX/MEM ALU fields.

Parameters:
- WIDTH, 16, datapath width in bits (even, >= 8).
- SHW, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  an instruction is presented this cycle
- flush  in  1  kill the current instruction and any multiply in flight
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 NOR, 4 SLL, 5 SRL, 6 SRA, 7 LHB, 8 MUL; 9-15 are NOP
- p0, p1  in  WIDTH  register-file read data
- imm8  in  8  immediate
- src1sel  in  1  1 selects the sign-extended imm8 as src1; 0 selects forwarded p1
- shamt  in  SHW  shift amount
- forwardA, forwardB  in  2  00 regfile, 01 wb_data, 10 or 11 mem_data
- mem_data, wb_data  in  WIDTH  forwarding sources
- busy  out  1  multiplier active; upstream must hold its inputs
- out_valid  out  1  dst/flags valid this cycle (registered)
- dst  out  WIDTH  registered result
- sdata  out  WIDTH  registered forwarded p1 (store data)
- N, Z, V  out  1  flag register

Behaviour:
- Reset: busy=0, out_valid=0, dst=0, sdata=0, N=Z=V=0, FSM=IDLE, multiplier counter=0.
- Forwarding: srcA = fwd(p0, forwardA); fwdB = fwd(p1, forwardB); code 11 behaves as 10 (mem priority). src1 = src1sel ? sext(imm8) : fwdB.
- Single-cycle ops (IDLE, in_valid=1, flush=0):
  - Result, sdata=fwdB and out_valid=1 are registered on the next edge (latency 1).
  - out_valid=0 on any cycle without an accepted completion.
- ADD/SUB:
  - Signed and saturating. On overflow, dst = max (0x7FFF) or min (0x8000) for WIDTH=16, and V=1.
  - N and Z reflect the saturated result. N, Z and V all update.
- AND, NOR, SLL, SRL, SRA: only Z updates; N and V hold.
- Shifts: shift amount is shamt (0 gives srcA unchanged); SRA sign-fills.
- LHB: dst = {imm8, srcA[WIDTH/2-1:0]}. No flags update.
- NOP (op 9-15): out_valid=1, dst=0, flags hold.
- MUL FSM:
  - IDLE -> RUN on accepted MUL. Capture srcA and src1, load counter=WIDTH, assert busy the same edge.
  - RUN: one shift-add step per cycle, counter decrements. When the counter reaches 1 the next edge goes to IDLE.
  - On that exit edge: dst = low WIDTH bits of the product, out_valid=1, busy=0. Z and N update from dst; V=1 if the signed product does not fit in WIDTH bits.
  - Total latency is WIDTH+1 edges from acceptance to out_valid.
- While busy: in_valid and other inputs are ignored; the stage must not accept a new instruction.
- Flush:
  - In IDLE, flush squashes the presented instruction: out_valid=0 next cycle, flags hold.
  - In RUN, flush returns to IDLE on the next edge: busy=0, out_valid=0, flags and dst hold.
  - Flush has priority over in_valid and over multiply completion in the same cycle.
- rst asserted mid-multiply: immediate return to the reset values; no partial result appears.
- A new instruction is accepted on the cycle after busy falls (no same-edge back-to-back into a MUL completion).

Test Plan:
- WIDTH=16, ADD p0=0x7FF0, p1=0x0020, forward 00 -> next cycle dst=0x7FFF, V=1, N=0, Z=0, out_valid=1.
- SUB with forwardA=01 (wb_data=0x0005), forwardB=11 (mem_data=0x0005), p0=p1=0x1234 -> dst=0x0000, Z=1; proves mem priority and that p0/p1 are ignored.
- MUL 0x0003 x 0xFFFE (-2) -> busy high for 16 cycles, out_valid at edge 17, dst=0xFFFA, N=1, V=0; in_valid pulses during busy are ignored.
- MUL 0x4000 x 0x0004 -> dst=0x0000, V=1, Z=1; then AND 0x00FF,0x0F0F -> dst=0x000F, Z=0, with N and V held from the MUL.
- Flush at cycle 5 of a MUL -> busy=0 next edge, out_valid stays 0, flags unchanged; an ADD presented the following cycle completes normally.
- rst mid-MUL with an SRA pending (0x8000 >> 3) -> all outputs at reset values; after rst drops, SRA gives dst=0xF000, Z=0.

Source files
------------

// File: rtl/ex_stage_mc.sv
// Execute stage: forwarding muxes, saturating single-cycle ALU, and an iterative
// shift-add signed multiplier that holds the front of the pipe while it runs.
module ex_stage_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] p1,
  input  logic [7:0]       imm8,
  input  logic             src1sel,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] dst,
  output logic [WIDTH-1:0] sdata,
  output logic             N,
  output logic             Z,
  output logic             V
);
  localparam int CW = SHW + 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_NOR = 4'd3, OP_SLL = 4'd4,
    OP_SRL = 4'd5, OP_SRA = 4'd6, OP_LHB = 4'd7, OP_MUL = 4'd8
  } op_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   src_a, fwd_b, src1, sum, diff, alu_res, mplier;
  logic               alu_v, upd_n, upd_z, upd_v;
  logic               accept, mul_step, mul_done, mul_fits;
  logic [2*WIDTH-1:0] mcand, acc, partial, acc_nx;
  logic [CW-1:0]      cnt;

  always_comb begin
    case (forwardA)
      2'b00:   src_a = p0;
      2'b01:   src_a = wb_data;
      default: src_a = mem_data;
    endcase
    case (forwardB)
      2'b00:   fwd_b = p1;
      2'b01:   fwd_b = wb_data;
      default: fwd_b = mem_data;
    endcase
    src1 = src1sel ? WIDTH'($signed(imm8)) : fwd_b;
  end

  always_comb begin
    sum     = src_a + src1;
    diff    = src_a - src1;
    alu_res = '0;
    alu_v   = 1'b0;
    upd_n   = 1'b0;
    upd_z   = 1'b0;
    upd_v   = 1'b0;
    case (op)
      OP_ADD: begin
        {upd_n, upd_z, upd_v} = 3'b111;
        alu_v   = (src_a[WIDTH-1] == src1[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
        alu_res = alu_v ? (src_a[WIDTH-1] ? SMIN : SMAX) : sum;
      end
      OP_SUB: begin
        {upd_n, upd_z, upd_v} = 3'b111;
        alu_v   = (src_a[WIDTH-1] != src1[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
        alu_res = alu_v ? (src_a[WIDTH-1] ? SMIN : SMAX) : diff;
      end
      OP_AND: begin upd_z = 1'b1; alu_res = src_a & src1; end
      OP_NOR: begin upd_z = 1'b1; alu_res = ~(src_a | src1); end
      OP_SLL: begin upd_z = 1'b1; alu_res = src_a << shamt; end
      OP_SRL: begin upd_z = 1'b1; alu_res = src_a >> shamt; end
      OP_SRA: begin upd_z = 1'b1; alu_res = $signed(src_a) >>> shamt; end
      OP_LHB: alu_res = {(WIDTH/2)'(imm8), src_a[WIDTH/2-1:0]};
      default: alu_res = '0;
    endcase
  end

  // Signed shift-add: multiplicand is sign-extended and the multiplier MSB
  // carries negative weight, so the final step (cnt==1) subtracts.
  always_comb begin
    partial  = mplier[0] ? mcand : '0;
    acc_nx   = (cnt == CW'(1)) ? acc - partial : acc + partial;
    mul_fits = (&acc_nx[2*WIDTH-1:WIDTH-1]) | ~(|acc_nx[2*WIDTH-1:WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && op == OP_MUL)      state_nx = RUN;
      RUN:  if (flush || cnt == CW'(1))       state_nx = IDLE;
      default:                                state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    accept   = (state == IDLE) && in_valid && !flush;
    mul_step = (state == RUN) && !flush;
    mul_done = mul_step && (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dst       <= '0;
      sdata     <= '0;
      N         <= 1'b0;
      Z         <= 1'b0;
      V         <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          mcand  <= (2*WIDTH)'($signed(src_a));
          mplier <= src1;
          acc    <= '0;
          cnt    <= CW'(WIDTH);
        end else begin
          out_valid <= 1'b1;
          dst       <= alu_res;
          sdata     <= fwd_b;
          if (upd_n) N <= alu_res[WIDTH-1];
          if (upd_z) Z <= ~(|alu_res);
          if (upd_v) V <= alu_v;
        end
      end else if (mul_step) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (mul_done) begin
          out_valid <= 1'b1;
          dst       <= acc_nx[WIDTH-1:0];
          N         <= acc_nx[WIDTH-1];
          Z         <= ~(|acc_nx[WIDTH-1:0]);
          V         <= ~mul_fits;
        end
      end else if (busy) begin
        cnt <= '0;
      end
    end
  end
endmodule
